// File: rtl/irq_moderator.sv
// Interrupt moderation stage in front of the MSI block. It coalesces
// per-vector event pulses by count threshold and holdoff timer, latches
// software-visible pending bits, and emits one-cycle irq pulses.
module irq_moderator #(
  parameter int NUM_VEC = 8,
  parameter int CNT_W   = 8,
  parameter int TIMER_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  // 'event' is a reserved word in SystemVerilog, so the pulse input is named events.
  input  logic [NUM_VEC-1:0] events,
  input  logic [3:0]         avs_address,
  input  logic               avs_read,
  output logic [31:0]        avs_readdata,
  input  logic               avs_write,
  input  logic [31:0]        avs_writedata,
  output logic [NUM_VEC-1:0] irq
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_FIRE  = 2'd2,
    S_HOLD  = 2'd3
  } vec_state_t;

  localparam logic [3:0]         ADDR_STATUS = 4'h0;
  localparam logic [3:0]         ADDR_MASK   = 4'h1;
  localparam logic [3:0]         ADDR_MISSED = 4'h2;
  localparam logic [CNT_W-1:0]   CNT_MAX     = '1;
  localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);
  localparam logic [TIMER_W-1:0] TIMER_ONE   = TIMER_W'(1);

  // A programmed threshold of zero behaves like one.
  function automatic logic [CNT_W-1:0] eff_thresh(input logic [CNT_W-1:0] t);
    return (t == '0) ? CNT_ONE : t;
  endfunction

  function automatic logic thresh_is_one(input logic [CNT_W-1:0] t);
    return (t <= CNT_ONE);
  endfunction

  // CSR state
  logic [NUM_VEC-1:0] status_q, mask_q, missed_q;
  logic [NUM_VEC-1:0] mask_rise_q;  // mask bit went 0->1 on the previous cycle
  logic [NUM_VEC-1:0] irq_q;        // irq as driven on the previous cycle
  logic [CNT_W-1:0]   thresh_q  [NUM_VEC];
  logic [TIMER_W-1:0] timeout_q [NUM_VEC];

  // Per-vector coalescing state
  vec_state_t         state_q [NUM_VEC];
  vec_state_t         state_d [NUM_VEC];
  logic [CNT_W-1:0]   cnt_q   [NUM_VEC];
  logic [CNT_W-1:0]   cnt_d   [NUM_VEC];
  logic [TIMER_W-1:0] timer_q [NUM_VEC];
  logic [TIMER_W-1:0] timer_d [NUM_VEC];

  logic [NUM_VEC-1:0] fire, missed_set, missed_clr, irq_raw;
  logic [NUM_VEC-1:0] status_clr, mask_rise_d;
  logic               wr_mask, wr_cfg;
  logic [2:0]         cfg_idx;
  logic [31:0]        rd_mux;
  logic               unused_wdata;

  assign status_clr  = (avs_write && avs_address == ADDR_STATUS) ? avs_writedata[NUM_VEC-1:0] : '0;
  assign wr_mask     = avs_write && avs_address == ADDR_MASK;
  assign wr_cfg      = avs_write && avs_address[3];
  assign cfg_idx     = avs_address[2:0];
  assign mask_rise_d = wr_mask ? (avs_writedata[NUM_VEC-1:0] & ~mask_q) : '0;
  assign unused_wdata = ^avs_writedata[15:CNT_W];

  // Next-state logic of the per-vector coalescing FSMs.
  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    fire       = '0;
    missed_set = '0;
    missed_clr = '0;
    for (int i = 0; i < NUM_VEC; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      timer_d[i] = timer_q[i];
      unique case (state_q[i])
        S_IDLE: begin
          if (events[i]) begin
            cnt_d[i]   = CNT_ONE;
            timer_d[i] = timeout_q[i];
            state_d[i] = thresh_is_one(thresh_q[i]) ? S_FIRE : S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (events[i] && cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + CNT_ONE;
          // A timer loaded with zero never counts, which disables the holdoff.
          if (timer_q[i] != '0) timer_d[i] = timer_q[i] - TIMER_ONE;
          if (cnt_d[i] >= eff_thresh(thresh_q[i]) || timer_q[i] == TIMER_ONE)
            state_d[i] = S_FIRE;
        end
        S_FIRE: begin
          fire[i]       = 1'b1;
          cnt_d[i]      = '0;
          state_d[i]    = S_HOLD;
          missed_set[i] = events[i];
        end
        S_HOLD: begin
          if (status_clr[i]) begin
            missed_clr[i] = 1'b1;
            if (missed_q[i] || events[i]) begin
              cnt_d[i]   = CNT_ONE;
              timer_d[i] = timeout_q[i];
              state_d[i] = thresh_is_one(thresh_q[i]) ? S_FIRE : S_ACCUM;
            end else begin
              state_d[i] = S_IDLE;
            end
          end else begin
            missed_set[i] = events[i];
          end
        end
        default: state_d[i] = S_IDLE;
      endcase
    end
  end

  // Pulse on FIRE when enabled, or when a pending vector is unmasked;
  // a pulse is never allowed to follow directly on another.
  always_comb begin
    irq_raw = '0;
    for (int i = 0; i < NUM_VEC; i++) begin
      irq_raw[i] = (state_q[i] == S_FIRE && mask_q[i]) ||
                   (state_q[i] == S_HOLD && mask_rise_q[i]);
    end
  end

  assign irq = irq_raw & ~irq_q;

  // Register the FSM state, counters and timers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_VEC; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
        timer_q[i] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      for (int i = 0; i < NUM_VEC; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        timer_q[i] <= timer_d[i];
      end
    end
  end

  // CSR registers: W1C status (set wins), mask, missed, per-vector config.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      status_q    <= '0;
      mask_q      <= '0;
      missed_q    <= '0;
      mask_rise_q <= '0;
      irq_q       <= '0;
      // NOTE: the config arrays are a handful of flops with defined reset values, not a RAM, so they are reset.
      for (int i = 0; i < NUM_VEC; i++) begin
        thresh_q[i]  <= CNT_ONE;
        timeout_q[i] <= '0;
      end
    end else begin
      status_q    <= (status_q & ~status_clr) | fire;
      missed_q    <= (missed_q & ~missed_clr) | missed_set;
      mask_rise_q <= mask_rise_d;
      irq_q       <= irq;
      if (wr_mask) mask_q <= avs_writedata[NUM_VEC-1:0];
      if (wr_cfg) begin
        thresh_q[cfg_idx]  <= avs_writedata[CNT_W-1:0];
        timeout_q[cfg_idx] <= avs_writedata[TIMER_W+15:16];
      end
    end
  end

  // CSR read multiplexer; unmapped addresses read as zero.
  always_comb begin
    rd_mux = '0;
    if (avs_address[3]) begin
      rd_mux[CNT_W-1:0]     = thresh_q[cfg_idx];
      rd_mux[TIMER_W+15:16] = timeout_q[cfg_idx];
    end else begin
      unique case (avs_address)
        ADDR_STATUS: rd_mux[NUM_VEC-1:0] = status_q;
        ADDR_MASK:   rd_mux[NUM_VEC-1:0] = mask_q;
        ADDR_MISSED: rd_mux[NUM_VEC-1:0] = missed_q;
        default:     rd_mux = '0;
      endcase
    end
  end

  // Read data is registered: valid the cycle after avs_read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) avs_readdata <= '0;
    else          avs_readdata <= avs_read ? rd_mux : 32'h0;
  end

endmodule
